cmsdk_mcu_mtx4x2_in_stage: RTL and testbench

Slave-side input stage of the 4x2 bus matrix: one instance per slave port, sitting between the external AHB-Lite master and that port's decoder. It presents the current address phase to the decoder. When the decoder reports the required output stage busy (`active_in` low), it captures the transfer in a holding register and stalls the master. It replays the held transfer as NONSEQ once the output stage accepts it, and returns downstream HREADYOUT/HRESP to the master.

---
 rtl/cmsdk_mcu_mtx4x2_pkg.sv | 23 ++
 rtl/cmsdk_mcu_mtx4x2_hold_reg.sv | 62 ++++++
 rtl/cmsdk_mcu_mtx4x2_in_stage.sv | 172 +++++++++++++++++
 tb/tb_cmsdk_mcu_mtx4x2_in_stage.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cmsdk_mcu_mtx4x2_pkg.sv
// ---------------------------------------------------------------------------
// cmsdk_mcu_mtx4x2_pkg
// Shared encodings for the 4x2 bus matrix: AHB-Lite HTRANS and HRESP values
// plus a small helper that classifies a transfer type.
// ---------------------------------------------------------------------------
package cmsdk_mcu_mtx4x2_pkg;

    // HTRANS encodings
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // HRESP encodings
    localparam logic [1:0] HRESP_OKAY    = 2'b00;
    localparam logic [1:0] HRESP_ERROR   = 2'b01;

    // NONSEQ and SEQ both carry a real transfer; IDLE and BUSY do not
    function automatic logic trans_is_active(input logic [1:0] trans);
        return trans[1];
    endfunction

endpackage

// File: rtl/cmsdk_mcu_mtx4x2_hold_reg.sv
// ---------------------------------------------------------------------------
// cmsdk_mcu_mtx4x2_hold_reg
// Enable-loaded register bank holding one AHB address phase (address and
// control) while the input stage waits for its output stage.
// Ports:
//   HCLK, HRESETn         clock, async active-low reset (contents clear to 0)
//   load_en               capture the d-side values on this edge
//   *_d                   live address/control from the master
//   *_r                   held address/control
// ---------------------------------------------------------------------------
module cmsdk_mcu_mtx4x2_hold_reg #(
    parameter int UW = 3
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic          load_en,
    input  logic [31:0]   addr_d,
    input  logic          write_d,
    input  logic [2:0]    size_d,
    input  logic [2:0]    burst_d,
    input  logic [3:0]    prot_d,
    input  logic          mastlock_d,
    input  logic [UW-1:0] auser_d,
    output logic [31:0]   addr_r,
    output logic          write_r,
    output logic [2:0]    size_r,
    output logic [2:0]    burst_r,
    output logic [3:0]    prot_r,
    output logic          mastlock_r,
    output logic [UW-1:0] auser_r
);

    // Capture the address phase when loading; otherwise keep the held copy
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            addr_r     <= 32'h0000_0000;
            write_r    <= 1'b0;
            size_r     <= 3'b000;
            burst_r    <= 3'b000;
            prot_r     <= 4'b0000;
            mastlock_r <= 1'b0;
            auser_r    <= {UW{1'b0}};
        end else if (load_en) begin
            addr_r     <= addr_d;
            write_r    <= write_d;
            size_r     <= size_d;
            burst_r    <= burst_d;
            prot_r     <= prot_d;
            mastlock_r <= mastlock_d;
            auser_r    <= auser_d;
        end else begin
            addr_r     <= addr_r;
            write_r    <= write_r;
            size_r     <= size_r;
            burst_r    <= burst_r;
            prot_r     <= prot_r;
            mastlock_r <= mastlock_r;
            auser_r    <= auser_r;
        end
    end

endmodule

// File: rtl/cmsdk_mcu_mtx4x2_in_stage.sv
// ---------------------------------------------------------------------------
// cmsdk_mcu_mtx4x2_in_stage
// Slave-side input stage of the 4x2 bus matrix. Passes the master's address
// phase straight to the decoder when the output stage is free; otherwise
// holds it, stalls the master, and replays it as NONSEQ once accepted.
// Ports:
//   HCLK, HRESETn                 clock, async active-low reset
//   HSELS..HAUSERS, HREADYS       address phase from the AHB-Lite master
//   active_in, readyout_in,
//   resp_in                       status from the decoder/output stage
//   sel_in..auser_in              address phase presented to the decoder
//   held_tran_in                  presented transfer comes from the hold reg
//   HREADYOUTS, HRESPS            response to the master
// ---------------------------------------------------------------------------
module cmsdk_mcu_mtx4x2_in_stage
    import cmsdk_mcu_mtx4x2_pkg::*;
#(
    parameter int UW = 3
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic          HSELS,
    input  logic [31:0]   HADDRS,
    input  logic [1:0]    HTRANSS,
    input  logic          HWRITES,
    input  logic [2:0]    HSIZES,
    input  logic [2:0]    HBURSTS,
    input  logic [3:0]    HPROTS,
    input  logic          HMASTLOCKS,
    input  logic [UW-1:0] HAUSERS,
    input  logic          HREADYS,
    input  logic          active_in,
    input  logic          readyout_in,
    input  logic [1:0]    resp_in,
    output logic          sel_in,
    output logic [31:0]   addr_in,
    output logic [1:0]    trans_in,
    output logic          write_in,
    output logic [2:0]    size_in,
    output logic [2:0]    burst_in,
    output logic [3:0]    prot_in,
    output logic          mastlock_in,
    output logic [UW-1:0] auser_in,
    output logic          held_tran_in,
    output logic          HREADYOUTS,
    output logic [1:0]    HRESPS
);

    logic          pend_r;
    logic          dphase_r;
    logic          pend_nxt_s;
    logic          dphase_nxt_s;
    logic          trans_valid_s;
    logic          load_en_s;
    logic          accept_s;

    logic [31:0]   hold_addr_s;
    logic          hold_write_s;
    logic [2:0]    hold_size_s;
    logic [2:0]    hold_burst_s;
    logic [3:0]    hold_prot_s;
    logic          hold_mastlock_s;
    logic [UW-1:0] hold_auser_s;

    assign trans_valid_s = HSELS & trans_is_active(HTRANSS) & HREADYS;
    // Loading is blocked while already pending; HREADYS is low then anyway
    assign load_en_s     = trans_valid_s & ~active_in & ~pend_r;
    // An address phase is accepted downstream either live or from the hold reg
    assign accept_s      = pend_r ? (active_in & readyout_in)
                                  : (trans_valid_s & active_in);

    cmsdk_mcu_mtx4x2_hold_reg #(.UW(UW)) u_hold_reg (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .load_en    (load_en_s),
        .addr_d     (HADDRS),
        .write_d    (HWRITES),
        .size_d     (HSIZES),
        .burst_d    (HBURSTS),
        .prot_d     (HPROTS),
        .mastlock_d (HMASTLOCKS),
        .auser_d    (HAUSERS),
        .addr_r     (hold_addr_s),
        .write_r    (hold_write_s),
        .size_r     (hold_size_s),
        .burst_r    (hold_burst_s),
        .prot_r     (hold_prot_s),
        .mastlock_r (hold_mastlock_s),
        .auser_r    (hold_auser_s)
    );

    // Next-state for the pending flag and the downstream data-phase flag
    always_comb begin
        pend_nxt_s   = pend_r;
        dphase_nxt_s = dphase_r;
        if (pend_r) begin
            if (accept_s) begin
                pend_nxt_s = 1'b0;
            end else begin
                pend_nxt_s = 1'b1;
            end
        end else if (load_en_s) begin
            pend_nxt_s = 1'b1;
        end else begin
            pend_nxt_s = 1'b0;
        end
        if (accept_s) begin
            dphase_nxt_s = 1'b1;
        end else if (dphase_r && readyout_in) begin
            dphase_nxt_s = 1'b0;
        end else begin
            dphase_nxt_s = dphase_r;
        end
    end

    // State registers
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            pend_r   <= 1'b0;
            dphase_r <= 1'b0;
        end else begin
            pend_r   <= pend_nxt_s;
            dphase_r <= dphase_nxt_s;
        end
    end

    // Address-phase mux: live inputs, or the held copy replayed as NONSEQ
    // since arbitration may have broken the original burst
    always_comb begin
        sel_in       = HSELS;
        addr_in      = HADDRS;
        trans_in     = HTRANSS;
        write_in     = HWRITES;
        size_in      = HSIZES;
        burst_in     = HBURSTS;
        prot_in      = HPROTS;
        mastlock_in  = HMASTLOCKS;
        auser_in     = HAUSERS;
        held_tran_in = 1'b0;
        if (pend_r) begin
            sel_in       = 1'b1;
            addr_in      = hold_addr_s;
            trans_in     = HTRANS_NONSEQ;
            write_in     = hold_write_s;
            size_in      = hold_size_s;
            burst_in     = hold_burst_s;
            prot_in      = hold_prot_s;
            mastlock_in  = hold_mastlock_s;
            auser_in     = hold_auser_s;
            held_tran_in = 1'b1;
        end else begin
            held_tran_in = 1'b0;
        end
    end

    // Master response: stall while pending, else mirror the downstream data phase
    always_comb begin
        HREADYOUTS = 1'b1;
        HRESPS     = HRESP_OKAY;
        if (pend_r) begin
            HREADYOUTS = 1'b0;
            HRESPS     = HRESP_OKAY;
        end else if (dphase_r) begin
            HREADYOUTS = readyout_in;
            HRESPS     = resp_in;
        end else begin
            HREADYOUTS = 1'b1;
            HRESPS     = HRESP_OKAY;
        end
    end

endmodule

// File: tb/tb_cmsdk_mcu_mtx4x2_in_stage.sv
// ---------------------------------------------------------------------------
// tb_cmsdk_mcu_mtx4x2_in_stage
// Directed scenarios followed by randomized traffic, all checked every cycle
// against a transaction-level model of the input stage.
// ---------------------------------------------------------------------------
module tb_cmsdk_mcu_mtx4x2_in_stage;

    localparam int UW = 3;

    typedef struct {
        logic          sel;
        logic [31:0]   addr;
        logic [1:0]    trans;
        logic          write;
        logic [2:0]    size;
        logic [2:0]    burst;
        logic [3:0]    prot;
        logic          lock;
        logic [UW-1:0] auser;
        logic          active;
        logic          rdy;
        logic [1:0]    resp;
    } stim_t;

    logic          HCLK;
    logic          HRESETn;
    logic          HSELS;
    logic [31:0]   HADDRS;
    logic [1:0]    HTRANSS;
    logic          HWRITES;
    logic [2:0]    HSIZES;
    logic [2:0]    HBURSTS;
    logic [3:0]    HPROTS;
    logic          HMASTLOCKS;
    logic [UW-1:0] HAUSERS;
    logic          HREADYS;
    logic          active_in;
    logic          readyout_in;
    logic [1:0]    resp_in;
    logic          sel_in;
    logic [31:0]   addr_in;
    logic [1:0]    trans_in;
    logic          write_in;
    logic [2:0]    size_in;
    logic [2:0]    burst_in;
    logic [3:0]    prot_in;
    logic          mastlock_in;
    logic [UW-1:0] auser_in;
    logic          held_tran_in;
    logic          HREADYOUTS;
    logic [1:0]    HRESPS;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: at most one parked transfer, and whether a data phase
    // owned by the downstream is still open
    bit    m_parked;
    stim_t m_park;
    bit    m_dp_open;

    cmsdk_mcu_mtx4x2_in_stage #(.UW(UW)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSELS(HSELS), .HADDRS(HADDRS),
        .HTRANSS(HTRANSS), .HWRITES(HWRITES), .HSIZES(HSIZES),
        .HBURSTS(HBURSTS), .HPROTS(HPROTS), .HMASTLOCKS(HMASTLOCKS),
        .HAUSERS(HAUSERS), .HREADYS(HREADYS), .active_in(active_in),
        .readyout_in(readyout_in), .resp_in(resp_in), .sel_in(sel_in),
        .addr_in(addr_in), .trans_in(trans_in), .write_in(write_in),
        .size_in(size_in), .burst_in(burst_in), .prot_in(prot_in),
        .mastlock_in(mastlock_in), .auser_in(auser_in),
        .held_tran_in(held_tran_in), .HREADYOUTS(HREADYOUTS), .HRESPS(HRESPS)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic stim_t mk(input logic sel, input logic [31:0] addr,
                                 input logic [1:0] trans, input logic active,
                                 input logic rdy, input logic [1:0] resp);
        stim_t s;
        s.sel    = sel;
        s.addr   = addr;
        s.trans  = trans;
        s.write  = 1'($urandom_range(0, 1));
        s.size   = 3'($urandom_range(0, 7));
        s.burst  = 3'($urandom_range(0, 7));
        s.prot   = 4'($urandom_range(0, 15));
        s.lock   = 1'($urandom_range(0, 1));
        s.auser  = UW'($urandom_range(0, 7));
        s.active = active;
        s.rdy    = rdy;
        s.resp   = resp;
        return s;
    endfunction

    function automatic logic model_ready(input stim_t s);
        if (m_parked) return 1'b0;
        if (m_dp_open) return s.rdy;
        return 1'b1;
    endfunction

    task automatic drive(input stim_t s);
        HSELS       = s.sel;
        HADDRS      = s.addr;
        HTRANSS     = s.trans;
        HWRITES     = s.write;
        HSIZES      = s.size;
        HBURSTS     = s.burst;
        HPROTS      = s.prot;
        HMASTLOCKS  = s.lock;
        HAUSERS     = s.auser;
        active_in   = s.active;
        readyout_in = s.rdy;
        resp_in     = s.resp;
        // single master on this port: bus HREADY is what the model says we return
        HREADYS     = model_ready(s);
    endtask

    task automatic check_outputs(input stim_t s);
        stim_t src;
        src = m_parked ? m_park : s;
        check_val("sel_in",      32'(sel_in),      32'(m_parked ? 1'b1 : s.sel));
        check_val("addr_in",     addr_in,          src.addr);
        check_val("trans_in",    32'(trans_in),    32'(m_parked ? 2'b10 : s.trans));
        check_val("write_in",    32'(write_in),    32'(src.write));
        check_val("size_in",     32'(size_in),     32'(src.size));
        check_val("burst_in",    32'(burst_in),    32'(src.burst));
        check_val("prot_in",     32'(prot_in),     32'(src.prot));
        check_val("mastlock_in", 32'(mastlock_in), 32'(src.lock));
        check_val("auser_in",    32'(auser_in),    32'(src.auser));
        check_val("held_tran",   32'(held_tran_in), 32'(m_parked));
        check_val("HREADYOUTS",  32'(HREADYOUTS),  32'(model_ready(s)));
        check_val("HRESPS",      32'(HRESPS),
                  32'((!m_parked && m_dp_open) ? s.resp : 2'b00));
    endtask

    // One bus cycle: drive at the falling edge, check, then advance the model
    task automatic step(input stim_t s);
        bit sampled;
        bit handed_over;
        drive(s);
        #1;
        check_outputs(s);
        @(posedge HCLK);
        sampled = s.sel && s.trans[1] && model_ready(s);
        if (m_parked) begin
            handed_over = s.active && s.rdy;
            if (handed_over) m_parked = 1'b0;
        end else begin
            handed_over = sampled && s.active;
            if (sampled && !s.active) begin
                m_parked = 1'b1;
                m_park   = s;
            end
        end
        if (handed_over) m_dp_open = 1'b1;
        else if (m_dp_open && s.rdy) m_dp_open = 1'b0;
        @(negedge HCLK);
    endtask

    task automatic do_reset(input stim_t s);
        HRESETn = 1'b0;
        m_parked  = 1'b0;
        m_dp_open = 1'b0;
        drive(s);
        #1;
        check_outputs(s);
        @(posedge HCLK);
        @(negedge HCLK);
        HRESETn = 1'b1;
    endtask

    stim_t s;

    initial begin
        m_parked  = 1'b0;
        m_dp_open = 1'b0;
        m_park    = mk(1'b0, 32'h0, 2'b00, 1'b0, 1'b1, 2'b00);
        HRESETn   = 1'b0;
        drive(mk(1'b0, 32'h0, 2'b00, 1'b0, 1'b1, 2'b00));
        @(negedge HCLK);
        // Reset state with live inputs
        do_reset(mk(1'b1, 32'h1234_5678, 2'b11, 1'b0, 1'b0, 2'b01));

        // Granted pass-through and its data phase
        step(mk(1'b1, 32'h2000_0000, 2'b10, 1'b1, 1'b1, 2'b00));
        step(mk(1'b0, 32'h0000_0000, 2'b00, 1'b1, 1'b1, 2'b00));

        // Hold and replay: three stalled cycles, then released
        s = mk(1'b1, 32'h0000_0040, 2'b11, 1'b0, 1'b1, 2'b00);
        step(s);
        step(s);
        step(s);
        step(s);
        s.active = 1'b1;
        step(s);
        step(mk(1'b0, 32'h0, 2'b00, 1'b1, 1'b1, 2'b00));

        // Downstream wait states
        step(mk(1'b1, 32'h3000_0010, 2'b10, 1'b1, 1'b1, 2'b00));
        step(mk(1'b0, 32'h0, 2'b00, 1'b1, 1'b0, 2'b00));
        step(mk(1'b0, 32'h0, 2'b00, 1'b1, 1'b0, 2'b00));
        step(mk(1'b0, 32'h0, 2'b00, 1'b1, 1'b1, 2'b00));

        // ERROR over two cycles, then a live IDLE
        step(mk(1'b1, 32'h4000_0000, 2'b10, 1'b1, 1'b1, 2'b00));
        step(mk(1'b1, 32'h4000_0004, 2'b00, 1'b1, 1'b0, 2'b01));
        step(mk(1'b1, 32'h4000_0004, 2'b00, 1'b1, 1'b1, 2'b01));
        step(mk(1'b1, 32'h4000_0004, 2'b00, 1'b1, 1'b1, 2'b00));

        // Reset mid-hold: no replay afterwards
        s = mk(1'b1, 32'h5000_0080, 2'b10, 1'b0, 1'b1, 2'b00);
        step(s);
        step(s);
        do_reset(mk(1'b0, 32'h0, 2'b00, 1'b1, 1'b1, 2'b00));
        step(mk(1'b0, 32'h0, 2'b00, 1'b1, 1'b1, 2'b00));

        // Unselected and IDLE: nothing loads
        step(mk(1'b0, 32'h6000_0000, 2'b10, 1'b0, 1'b1, 2'b00));
        step(mk(1'b1, 32'h6000_0000, 2'b00, 1'b0, 1'b1, 2'b00));
        step(mk(1'b1, 32'h6000_0000, 2'b01, 1'b0, 1'b1, 2'b00));

        // Randomized traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            s = mk(1'($urandom_range(0, 3) != 0), $urandom,
                   2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 3) != 0), {1'b0, 1'($urandom_range(0, 1))});
            if ($urandom_range(0, 99) == 0) do_reset(s);
            else step(s);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
